alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencing controller and two-port round-robin arbiter for the shared 32-bit combinational `alu`. It accepts operation requests (a, b, f) from two independent requesters over valid/ready handshakes and latches the winner's operands. It drives the ALU from registers and returns a registered result tagged with the requester id. It sits between the two datapath clients and the single ALU instance, so the ALU has exactly one owner.

## Interface

- DATA_W, 32, operand/result width; must equal the `alu` width (32).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has an operation pending.
- r0_ready  out  1  requester 0 request accepted this cycle.
- r0_a, r0_b  in  DATA_W  requester 0 operands.
- r0_f  in  3  requester 0 opcode (0 AND, 1 OR, 2 NAND, 3 NOR, 4 ADD, 5 SUB, 6 MUL, 7 illegal).
- r1_valid, r1_ready, r1_a, r1_b, r1_f: same as requester 0, for requester 1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_y  out  DATA_W  result.
- out_id  out  1  requester that issued the result.
- out_err  out  1  illegal opcode flag (see Configuration).

## Operation

- FSM states: IDLE, EXEC, DONE.
- IDLE: if any rN_valid, grant one requester: rN_ready=1 for the winner only, same cycle (combinational from state and valids). Latch a, b, f and id. Go to EXEC. If no request is valid, stay in IDLE.
- Arbitration: last_grant register. If only one requester is valid, it wins. If both are valid, the requester ≠ last_grant wins. last_grant updates on every grant.
- EXEC: the ALU sees the latched operands. Register its y into out_y, and set out_id. Go to DONE.
- DONE: out_valid=1. Hold out_y, out_id and out_err stable until out_ready=1, then go to IDLE. Both rN_ready stay 0 in EXEC and DONE.
- Arithmetic follows the ALU: ADD and SUB wrap modulo 2^32, MUL returns the low 32 bits, SUB is a−b.
- Requesters must hold valid, a, b and f stable until ready. Withdrawing a request before ready is a protocol violation, and the bench asserts on it.

## Timing

- Reset values: state=IDLE, out_valid=0, out_y=0, out_id=0, out_err=0, r0_ready=r1_ready=0, last_grant=1. With last_grant=1, r0 wins the first contended grant.
- Latency: grant in cycle T, out_valid=1 in cycle T+2.
- Minimum issue interval is 3 cycles, reached when out_ready is already high in DONE.
- out_ready held low: remain in DONE indefinitely. Pending requests wait and are not reordered.
- rst asserted in any state: next cycle state=IDLE and all outputs take their reset values. An in-flight result is discarded without a handshake.
- A request that becomes valid in the same cycle the FSM leaves DONE is seen in IDLE one cycle later.

## Configuration

- ALU_ARB_ERR_CHK_EN defined: if the latched f=7, EXEC does not use the ALU result. DONE then presents out_y=0 and out_err=1. All other opcodes give out_err=0.
- ALU_ARB_ERR_CHK_EN undefined: out_err is tied to 0. For f=7, out_y is whatever the ALU drives and is treated as don't-care. Timing is identical in both builds.

## Structure

- Shared package alu_pkg holds:
  - opcode constants OP_AND=0, OP_OR=1, OP_NAND=2, OP_NOR=3, OP_ADD=4, OP_SUB=5, OP_MUL=6, OP_ILL=7;
  - DATA_W;
  - FSM state encoding.
- One sub-module: the existing combinational `alu` (a, b, f, y), instantiated once and driven from the latched operand registers.
- Round-robin logic and the FSM are inline; no further sub-modules.

## Test plan

- Reset, then r0 requests a=5, b=3, f=4 with out_ready=1: r0_ready in T; out_valid in T+2 with out_y=8, out_id=0, out_err=0; back in IDLE at T+3.
- Both valid from reset: r0 (a=0xFFFFFFFF, b=1, f=4) and r1 (a=2, b=3, f=5). Grants go r0 then r1. Results are 0x00000000 (id 0), then 0xFFFFFFFF (id 1).
- Both held valid for 6 grants: ids alternate 0,1,0,1,0,1. MUL with a=0x10000, b=0x10000 returns 0.
- out_ready held low for 10 cycles in DONE: out_y and out_id stay stable and no rN_ready pulses. Releasing out_ready completes the handshake and the next grant follows.
- rst pulsed during EXEC: out_valid stays 0, the result is never presented and last_grant=1. A new r1 request is then served normally.
- f=7 from r1: with ALU_ARB_ERR_CHK_EN, out_y=0 and out_err=1. Without it, out_err=0 and out_y is not checked.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port sequencing arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: AND/OR/NAND/NOR/ADD/SUB/MUL, illegal opcode yields 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        f,
    output logic [DATA_W-1:0] y
);

    // Opcode decode; add/sub wrap and mul keeps the low word.
    always_comb begin
        y = '0;
        case (f)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end that owns the single shared ALU instance.
// Latency: grant in cycle T, registered result with out_valid in cycle T+2.
// Backpressure: result held in DONE until out_ready; no new grant until then.
// Optional build macro ALU_ARB_ERR_CHK_EN: flags opcode 7 with out_err=1 and out_y=0.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [2:0]        r0_f,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [2:0]        r1_f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_id,
    output logic              out_err
);

    state_t            state_q;
    state_t            state_d;
    logic              last_grant_q;
    logic              grant_vld;
    logic              grant_id;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        f_q;
    logic              id_q;
    logic [DATA_W-1:0] y_q;
    logic              res_id_q;
    logic              err_q;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] res_y;
    logic              res_err;

    alu u_alu (
        .a (a_q),
        .b (b_q),
        .f (f_q),
        .y (alu_y)
    );

`ifdef ALU_ARB_ERR_CHK_EN
    // Illegal opcode suppresses the ALU output and raises the error flag.
    assign res_err = (f_q == OP_ILL);
    assign res_y   = res_err ? '0 : alu_y;
`else
    assign res_err = 1'b0;
    assign res_y   = alu_y;
`endif

    // Next-state, grant and handshake outputs; grants are suppressed while rst is high
    // so no request is acknowledged and then discarded by the reset.
    always_comb begin
        state_d   = state_q;
        r0_ready  = 1'b0;
        r1_ready  = 1'b0;
        out_valid = 1'b0;
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && (r0_valid || r1_valid)) begin
                    grant_vld = 1'b1;
                    // Contention goes to whoever did not win last; otherwise the lone requester.
                    if (r0_valid && r1_valid) grant_id = ~last_grant_q;
                    else                      grant_id = r1_valid;
                    r0_ready = ~grant_id;
                    r1_ready = grant_id;
                    state_d  = EXEC;
                end
            end
            EXEC: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand latch on grant, result capture in EXEC; reset drops any in-flight result.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            f_q          <= OP_AND;
            id_q         <= 1'b0;
            y_q          <= '0;
            res_id_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            if (grant_vld) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
                a_q          <= grant_id ? r1_a : r0_a;
                b_q          <= grant_id ? r1_b : r0_b;
                f_q          <= grant_id ? r1_f : r0_f;
            end
            if (state_q == EXEC) begin
                y_q      <= res_y;
                res_id_q <= id_q;
                err_q    <= res_err;
            end
        end
    end

    assign out_y   = y_q;
    assign out_id  = res_id_q;
    assign out_err = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard filled on each grant, drained on each result.
// Latency: checks grant-to-result spacing and issue interval.
// Backpressure: exercises out_ready held low and reset during execution.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] y;
        logic        id;
        logic        err;
        bit          chk_y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic        r0_ready, r1_ready;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0]  r0_f = '0, r1_f = '0;
    logic        out_valid, out_id, out_err;
    logic        out_ready = 1'b0;
    logic [31:0] out_y;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    bit          p0 = 1'b0, p1 = 1'b0;
    logic [31:0] pa0, pb0, pa1, pb1;
    logic [2:0]  pf0, pf1;

    logic [31:0] t0a [3] = '{32'h0001_0000, 32'h0000_F0F0, 32'h0000_0001};
    logic [31:0] t0b [3] = '{32'h0001_0000, 32'h0000_0FF0, 32'h0000_0002};
    logic [2:0]  t0f [3] = '{3'd6, 3'd0, 3'd3};
    logic [31:0] t1a [3] = '{32'h0000_00A0, 32'hFFFF_0000, 32'h0000_0003};
    logic [31:0] t1b [3] = '{32'h0000_0005, 32'h00FF_FF00, 32'h0000_0005};
    logic [2:0]  t1f [3] = '{3'd1, 3'd2, 3'd5};

    alu_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r0_f      (r0_f),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .r1_f      (r1_f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_id    (out_id),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] f);
        exp_t e;
        e.id = id;
        case (f)
            3'd0: e.y = a & b;
            3'd1: e.y = a | b;
            3'd2: e.y = ~(a & b);
            3'd3: e.y = ~(a | b);
            3'd4: e.y = a + b;
            3'd5: e.y = a - b;
            3'd6: e.y = a * b;
            default: e.y = 32'd0;
        endcase
`ifdef ALU_ARB_ERR_CHK_EN
        e.err   = (f == 3'd7);
        e.chk_y = 1'b1;
`else
        e.err   = 1'b0;
        e.chk_y = (f != 3'd7);
`endif
        return e;
    endfunction

    // Grant monitor: pushes expectations, flags double grants and requester protocol breaks.
    always @(negedge clk) begin
        if (rst) begin
            p0 = 1'b0;
            p1 = 1'b0;
        end else begin
            if (r0_ready || r1_ready) begin
                total++;
                if (r0_ready && r1_ready) begin
                    bad++;
                    $display("FAIL dual_grant r0_ready=%b r1_ready=%b want one-hot", r0_ready, r1_ready);
                end
            end
            if (p0) begin
                total++;
                if (!(r0_valid === 1'b1 && r0_a === pa0 && r0_b === pb0 && r0_f === pf0)) begin
                    bad++;
                    $display("FAIL proto_r0 valid=%b a=%h want held request a=%h", r0_valid, r0_a, pa0);
                end
            end
            if (p1) begin
                total++;
                if (!(r1_valid === 1'b1 && r1_a === pa1 && r1_b === pb1 && r1_f === pf1)) begin
                    bad++;
                    $display("FAIL proto_r1 valid=%b a=%h want held request a=%h", r1_valid, r1_a, pa1);
                end
            end
            if (r0_ready) sb.push_back(model(1'b0, r0_a, r0_b, r0_f));
            if (r1_ready) sb.push_back(model(1'b1, r1_a, r1_b, r1_f));
            p0 = r0_valid && !r0_ready;
            p1 = r1_valid && !r1_ready;
            pa0 = r0_a; pb0 = r0_b; pf0 = r0_f;
            pa1 = r1_a; pb1 = r1_b; pf1 = r1_f;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_r0(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        r0_valid = v; r0_a = a; r0_b = b; r0_f = f;
    endtask

    task automatic set_r1(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        r1_valid = v; r1_a = a; r1_b = b; r1_f = f;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst = 1'b1;
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_y !== 32'd0) begin bad++; $display("FAIL reset_out_y got=%h want=0", out_y); end
        total++; if (out_id !== 1'b0) begin bad++; $display("FAIL reset_out_id got=%b want=0", out_id); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err got=%b want=0", out_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b%b want=00", r0_ready, r1_ready);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_single();
        exp_t e;
        reset_dut();
        out_ready = 1'b1;
        set_r0(1'b1, 32'd5, 32'd3, OP_ADD);
        @(negedge clk);
        total++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            bad++; $display("FAIL single_grant got r0=%b r1=%b want r0=1 r1=0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t1_valid got=%b want=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_t2_valid got=%b want=1", out_valid); end
        total++; if (out_y !== 32'd8) begin bad++; $display("FAIL single_y got=%h want=8", out_y); end
        total++; if (out_id !== 1'b0) begin bad++; $display("FAIL single_id got=%b want=0", out_id); end
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL single_err got=%b want=0", out_err); end
        if (sb.size() > 0) e = sb.pop_front();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_t3_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_contention();
        exp_t e;
        bit g0, g1;
        int n, ng;
        logic [31:0] want_y;
        reset_dut();
        out_ready = 1'b1;
        set_r0(1'b1, 32'hFFFF_FFFF, 32'd1, OP_ADD);
        set_r1(1'b1, 32'd2, 32'd3, OP_SUB);
        n = 0; ng = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            @(negedge clk);
            g0 = r0_ready; g1 = r1_ready;
            if (g0 || g1) begin
                total++;
                if (g1 !== ng[0]) begin bad++; $display("FAIL contend_order grant%0d got id=%b want=%b", ng, g1, ng[0]); end
                ng++;
            end
            if (out_valid) begin
                want_y = (n == 0) ? 32'h0000_0000 : 32'hFFFF_FFFF;
                if (sb.size() == 0) begin total++; bad++; $display("FAIL contend_sb empty want entry"); end
                else begin
                    e = sb.pop_front();
                    total++; if (out_y !== e.y) begin bad++; $display("FAIL contend_y got=%h want=%h", out_y, e.y); end
                end
                total++; if (out_y !== want_y) begin bad++; $display("FAIL contend_const_y got=%h want=%h", out_y, want_y); end
                total++; if (out_id !== n[0]) begin bad++; $display("FAIL contend_id got=%b want=%b", out_id, n[0]); end
                n++;
            end
            @(posedge clk); #1;
            if (g0) r0_valid = 1'b0;
            if (g1) r1_valid = 1'b0;
        end
        if (n < 2) begin total++; bad++; $display("FAIL contend_timeout got=%0d results want=2", n); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        bit g0, g1;
        int n, k0, k1, c, lastg;
        reset_dut();
        out_ready = 1'b1;
        k0 = 0; k1 = 0; n = 0; lastg = -1;
        set_r0(1'b1, t0a[0], t0b[0], t0f[0]);
        set_r1(1'b1, t1a[0], t1b[0], t1f[0]);
        for (c = 0; c < 60 && n < 6; c++) begin
            @(negedge clk);
            g0 = r0_ready; g1 = r1_ready;
            if (g0 || g1) begin
                if (lastg >= 0) begin
                    total++;
                    if (c - lastg != 3) begin bad++; $display("FAIL b2b_interval got=%0d want=3", c - lastg); end
                end
                lastg = c;
            end
            if (out_valid) begin
                total++; if (out_id !== n[0]) begin bad++; $display("FAIL b2b_id result%0d got=%b want=%b", n, out_id, n[0]); end
                if (n == 0) begin
                    total++; if (out_y !== 32'd0) begin bad++; $display("FAIL b2b_mul_wrap got=%h want=0", out_y); end
                end
                if (sb.size() == 0) begin total++; bad++; $display("FAIL b2b_sb empty want entry"); end
                else begin
                    e = sb.pop_front();
                    total++; if (out_y !== e.y || out_err !== e.err) begin
                        bad++; $display("FAIL b2b_y result%0d got=%h/%b want=%h/%b", n, out_y, out_err, e.y, e.err);
                    end
                end
                n++;
            end
            @(posedge clk); #1;
            if (g0) begin k0++; if (k0 < 3) set_r0(1'b1, t0a[k0], t0b[k0], t0f[k0]); else r0_valid = 1'b0; end
            if (g1) begin k1++; if (k1 < 3) set_r1(1'b1, t1a[k1], t1b[k1], t1f[k1]); else r1_valid = 1'b0; end
        end
        if (n < 6) begin total++; bad++; $display("FAIL b2b_timeout got=%0d results want=6", n); end
    endtask

    task automatic test_stall();
        exp_t e;
        bit g0, got;
        reset_dut();
        out_ready = 1'b0;
        set_r0(1'b1, 32'h0000_1234, 32'h0000_0010, OP_ADD);
        set_r1(1'b1, 32'h0000_0099, 32'h0000_0003, OP_MUL);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            g0 = r0_ready;
            if (out_valid) got = 1'b1;
            else begin @(posedge clk); #1; if (g0) r0_valid = 1'b0; end
        end
        if (!got || sb.size() == 0) begin total++; bad++; $display("FAIL stall_first got_valid=%b want=1", got); end
        else begin
            e = sb[0];
            repeat (10) begin
                @(posedge clk); @(negedge clk);
                total++; if (out_valid !== 1'b1 || out_y !== e.y || out_id !== 1'b0) begin
                    bad++; $display("FAIL stall_hold got=%b/%h/%b want=1/%h/0", out_valid, out_y, out_id, e.y);
                end
                total++; if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
                    bad++; $display("FAIL stall_ready got=%b%b want=00", r0_ready, r1_ready);
                end
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
            @(negedge clk);
            e = sb.pop_front();
            total++; if (out_valid !== 1'b1 || out_y !== e.y) begin
                bad++; $display("FAIL stall_release got=%b/%h want=1/%h", out_valid, out_y, e.y);
            end
            @(negedge clk);
            total++; if (r1_ready !== 1'b1) begin bad++; $display("FAIL stall_next_grant got=%b want=1", r1_ready); end
            @(posedge clk); #1;
            r1_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    if (sb.size() == 0) begin total++; bad++; $display("FAIL stall_sb empty want entry"); end
                    else begin
                        e = sb.pop_front();
                        total++; if (out_y !== e.y || out_id !== 1'b1) begin
                            bad++; $display("FAIL stall_r1 got=%h/%b want=%h/1", out_y, out_id, e.y);
                        end
                    end
                end
            end
            if (!got) begin total++; bad++; $display("FAIL stall_r1_timeout got no result want one"); end
        end
    endtask

    task automatic test_reset_exec();
        exp_t e;
        bit g0, g1;
        int n;
        reset_dut();
        out_ready = 1'b1;
        set_r0(1'b1, 32'd7, 32'd9, OP_ADD);
        @(negedge clk);
        total++; if (r0_ready !== 1'b1) begin bad++; $display("FAIL rexec_grant got=%b want=1", r0_ready); end
        @(posedge clk); #1;
        r0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        repeat (3) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || out_y !== 32'd0) begin
                bad++; $display("FAIL rexec_discard got=%b/%h want=0/0", out_valid, out_y);
            end
        end
        @(posedge clk); #1;
        set_r0(1'b1, 32'd1, 32'd1, OP_OR);
        set_r1(1'b1, 32'h20, 32'h4, OP_SUB);
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            @(negedge clk);
            g0 = r0_ready; g1 = r1_ready;
            if (c == 0) begin
                total++; if (g0 !== 1'b1 || g1 !== 1'b0) begin
                    bad++; $display("FAIL rexec_last_grant got r0=%b r1=%b want r0=1 r1=0", g0, g1);
                end
            end
            if (out_valid) begin
                if (sb.size() == 0) begin total++; bad++; $display("FAIL rexec_sb empty want entry"); end
                else begin
                    e = sb.pop_front();
                    total++; if (out_y !== e.y || out_id !== n[0]) begin
                        bad++; $display("FAIL rexec_result got=%h/%b want=%h/%b", out_y, out_id, e.y, n[0]);
                    end
                end
                n++;
            end
            @(posedge clk); #1;
            if (g0) r0_valid = 1'b0;
            if (g1) r1_valid = 1'b0;
        end
        if (n < 2) begin total++; bad++; $display("FAIL rexec_timeout got=%0d results want=2", n); end
    endtask

    task automatic test_illegal();
        exp_t e;
        bit g1, got;
        reset_dut();
        out_ready = 1'b1;
        set_r1(1'b1, 32'h0000_1234, 32'h0000_0055, OP_ILL);
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            g1 = r1_ready;
            if (out_valid) begin
                got = 1'b1;
                if (sb.size() == 0) begin total++; bad++; $display("FAIL ill_sb empty want entry"); end
                else begin
                    e = sb.pop_front();
                    total++; if (out_err !== e.err || out_id !== 1'b1) begin
                        bad++; $display("FAIL ill_err got=%b/%b want=%b/1", out_err, out_id, e.err);
                    end
                    if (e.chk_y) begin
                        total++; if (out_y !== e.y) begin bad++; $display("FAIL ill_y got=%h want=%h", out_y, e.y); end
                    end
                end
            end
            @(posedge clk); #1;
            if (g1) r1_valid = 1'b0;
        end
        if (!got) begin total++; bad++; $display("FAIL ill_timeout got no result want one"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_stall();
        test_reset_exec();
        test_illegal();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
